// File: rtl/cpu_pkg.sv
// cpu_pkg: pc_control codes shared with the decoder and fetch FSM state encodings.
package cpu_pkg;
  localparam logic [2:0] PC_SEQ    = 3'b000;
  localparam logic [2:0] PC_JUMP   = 3'b001;
  localparam logic [2:0] PC_JR     = 3'b010;
  localparam logic [2:0] PC_BRANCH = 3'b011;
  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} fetch_state_e;
endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for sequential, J/JAL, JR and taken branch.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] jr_target_i,
  input  logic [2:0]  pc_control_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);
  logic unused_opcode;
  assign unused_opcode = ^instr_i[31:26];
  always_comb begin
    next_pc_o  = pc_control_i == PC_JUMP   ? {pc_plus4_i[31:28], instr_i[25:0], 2'b00} :
                 pc_control_i == PC_JR     ? {jr_target_i[31:2], 2'b00} :
                 pc_control_i == PC_BRANCH ? pc_plus4_i + {{14{instr_i[15]}}, instr_i[15:0], 2'b00} :
                                             pc_plus4_i;
    misalign_o = pc_control_i == PC_JR && |jr_target_i[1:0];
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the PC, fetches one word per instruction and steps the PC on exec_done.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        exec_done_i,
  input  logic [2:0]  pc_control_i,
  input  logic [31:0] jr_target_i,
  output logic        addr_err_o
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc;
  logic en_q, addr_err_q, addr_err_d, misalign, fire_fetch, fire_exec;
  // en_q keeps req low through reset and for the first clock after release
  assign imem_req_o    = en_q && state_q == FETCH;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = state_q == EXEC;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign addr_err_o    = addr_err_q;
  next_pc_calc u_next_pc (
    .pc_plus4_i  (pc_plus4_o),
    .instr_i     (instr_q),
    .jr_target_i (jr_target_i),
    .pc_control_i(pc_control_i),
    .next_pc_o   (next_pc),
    .misalign_o  (misalign)
  );
  always_comb begin
    fire_fetch = imem_req_o && imem_ready_i;
    fire_exec  = state_q == EXEC && exec_done_i;
    state_d    = fire_fetch ? EXEC : fire_exec ? FETCH : state_q;
    instr_d    = fire_fetch ? imem_rdata_i : instr_q;
    pc_d       = fire_exec ? next_pc : pc_q;
    addr_err_d = fire_exec && misalign;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      en_q       <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      en_q       <= 1'b1;
      addr_err_q <= addr_err_d;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch handshake, next-PC selection, wrap and reset abort.
module tb_pc_fetch_unit;
  logic clk = 1'b0, rst_n;
  logic imem_req, imem_ready, instr_valid, exec_done, addr_err;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, jr_target;
  logic [2:0] pc_control;
  int n_chk = 0, n_fail = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .imem_ready_i(imem_ready), .instr_o(instr), .instr_valid_o(instr_valid),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .exec_done_i(exec_done),
    .pc_control_i(pc_control), .jr_target_i(jr_target), .addr_err_o(addr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] word, input int waits, input logic [31:0] addr);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, addr);
      tick();
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    imem_rdata = word;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
    chk("fetch_instr", instr, word);
    chk("exec_req_low", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic exec(input logic [2:0] ctl, input logic [31:0] jr, input logic [31:0] exp_addr, input logic exp_err);
    exec_done = 1'b1;
    pc_control = ctl;
    jr_target = jr;
    tick();
    exec_done = 1'b0;
    pc_control = 3'b000;
    chk("next_addr", imem_addr, exp_addr);
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_valid", {31'd0, instr_valid}, 32'd0);
    chk("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
    pc_control = 3'b000; jr_target = 32'h0;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    // zero-wait memory: ready in the very cycle req first rises
    fetch(32'h2001_0005, 0, 32'h0);
    chk("t1_pc", pc, 32'h0);
    chk("t1_pc4", pc_plus4, 32'h4);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    chk("exec_ignore_ready", instr, 32'h2001_0005);
    chk("exec_hold_valid", {31'd0, instr_valid}, 32'd1);
    exec(3'b000, 32'h0, 32'h4, 1'b0);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("fetch_ignore_done", pc, 32'h4);
    fetch(32'h0000_0000, 3, 32'h4);
    exec(3'b010, 32'h10, 32'h10, 1'b0);
    fetch(32'h0800_0040, 0, 32'h10);
    exec(3'b001, 32'h0, 32'h100, 1'b0);
    fetch(32'h0, 1, 32'h100);
    exec(3'b010, 32'h20, 32'h20, 1'b0);
    fetch(32'h1000_FFFE, 0, 32'h20);
    exec(3'b011, 32'h0, 32'h1C, 1'b0);
    fetch(32'h0, 0, 32'h1C);
    exec(3'b010, 32'h20, 32'h20, 1'b0);
    fetch(32'h1000_FFFE, 0, 32'h20);
    exec(3'b000, 32'h0, 32'h24, 1'b0);
    fetch(32'h0, 0, 32'h24);
    exec(3'b010, 32'h203, 32'h200, 1'b1);
    tick();
    chk("err_one_cycle", {31'd0, addr_err}, 32'd0);
    fetch(32'h1000_FFFE, 0, 32'h200);
    exec(3'b110, 32'h0, 32'h204, 1'b0);
    fetch(32'h0, 0, 32'h204);
    exec(3'b010, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    fetch(32'h0, 0, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    exec(3'b000, 32'h0, 32'h0, 1'b0);
    fetch(32'h1000_FFFC, 0, 32'h0);
    exec(3'b011, 32'h0, 32'hFFFF_FFF4, 1'b0);
    fetch(32'h0800_0040, 0, 32'hFFFF_FFF4);
    exec(3'b001, 32'h0, 32'hF000_0100, 1'b0);
    fetch(32'h1234_5678, 2, 32'hF000_0100);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_exec_pc", pc, 32'h0);
    chk("rst_exec_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_exec_req", {31'd0, imem_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    exec(3'b010, 32'h0000_0400, 32'h0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_fetch_req", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_ready = 1'b0;
    chk("rst_discard", instr, 32'h0);
    chk("rst_discard_valid", {31'd0, instr_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    fetch(32'h0800_0040, 0, 32'h0);
    exec_done = 1'b1; pc_control = 3'b001;
    rst_n = 1'b0;
    tick();
    exec_done = 1'b0;
    chk("rst_wins_pc", pc, 32'h0);
    chk("rst_wins_valid", {31'd0, instr_valid}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
